// File: rtl/mem_write_arbiter_pkg.sv
// Shared types and widths for the renderer memory write arbiter.
// Source identifiers and the bus geometry of the memory controller.
package mem_write_arbiter_pkg;

    localparam int MEM_ADDR_WIDTH = 27;
    localparam int MEM_DATA_WIDTH = 128;
    localparam int MEM_CNT_WIDTH  = 16;

    typedef enum logic {
        MEM_SRC_FB  = 1'b0,
        MEM_SRC_BVH = 1'b1
    } mem_src_t;

    function automatic mem_src_t other_src(
        input mem_src_t s
    );
        return (s == MEM_SRC_FB) ? MEM_SRC_BVH
                                 : MEM_SRC_FB;
    endfunction

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Valid/ready write request bundle for the memory write path.
// Sources carry no tag; the controller link adds the source id.
interface mem_write_arbiter_if
    import mem_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_WIDTH,
    parameter int DATA_W = MEM_DATA_WIDTH
);

    logic                  valid;
    logic                  ready;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W/8-1:0]   mask;
    mem_src_t              src;

    modport master (
        output valid,
        output addr,
        output data,
        output mask,
        output src,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        input  mask,
        output ready
    );

endinterface

// File: rtl/mem_write_arbiter_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// A push while full is dropped, even if a pop happens the same cycle.
module mem_wr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == FULL_CNT);
            empty <= (cnt_nxt == '0);
        end
    end

    // Storage is not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Merges framebuffer and BVH write streams onto one controller port.
// BVH wins while its load is in progress; round-robin afterwards.
module mem_write_arbiter
    import mem_write_arbiter_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_WIDTH,
    parameter int DATA_W     = MEM_DATA_WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     bvh_init_done,
    mem_write_arbiter_if.slave       fb,
    mem_write_arbiter_if.slave       bvh,
    mem_write_arbiter_if.master      m,
    output logic [MEM_CNT_WIDTH-1:0] fb_count,
    output logic [MEM_CNT_WIDTH-1:0] bvh_count
);

    localparam int MASK_W = DATA_W / 8;
    localparam int PAY_W  = ADDR_W + DATA_W + MASK_W;

    logic             fb_full;
    logic             fb_empty;
    logic             fb_pop;
    logic [PAY_W-1:0] fb_rdata;
    logic             bvh_full;
    logic             bvh_empty;
    logic             bvh_pop;
    logic [PAY_W-1:0] bvh_rdata;

    logic             load;
    mem_src_t         sel;
    logic [PAY_W-1:0] sel_pay;

    logic             m_valid_q;
    logic [PAY_W-1:0] m_pay_q;
    mem_src_t         m_src_q;
    mem_src_t         rr_ptr;

    mem_wr_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fb_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fb.valid),
        .wdata  ({fb.addr, fb.data, fb.mask}),
        .full   (fb_full),
        .pop    (fb_pop),
        .rdata  (fb_rdata),
        .empty  (fb_empty)
    );

    mem_wr_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_bvh_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (bvh.valid),
        .wdata  ({bvh.addr, bvh.data, bvh.mask}),
        .full   (bvh_full),
        .pop    (bvh_pop),
        .rdata  (bvh_rdata),
        .empty  (bvh_empty)
    );

    assign fb.ready  = !fb_full;
    assign bvh.ready = !bvh_full;

    assign load = (!m_valid_q || m.ready)
               && (!fb_empty || !bvh_empty);

    // rr_ptr names the source preferred at the next contested grant.
    always_comb begin
        sel = MEM_SRC_FB;
        unique case ({!fb_empty, !bvh_empty})
            2'b10:   sel = MEM_SRC_FB;
            2'b01:   sel = MEM_SRC_BVH;
            2'b11:   sel = bvh_init_done ? rr_ptr
                                         : MEM_SRC_BVH;
            default: sel = MEM_SRC_FB;
        endcase
    end

    assign sel_pay = (sel == MEM_SRC_BVH) ? bvh_rdata
                                          : fb_rdata;
    assign fb_pop  = load && (sel == MEM_SRC_FB);
    assign bvh_pop = load && (sel == MEM_SRC_BVH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid_q <= 1'b0;
            m_pay_q   <= '0;
            m_src_q   <= MEM_SRC_FB;
            rr_ptr    <= MEM_SRC_FB;
            fb_count  <= '0;
            bvh_count <= '0;
        end else if (load) begin
            m_valid_q <= 1'b1;
            m_pay_q   <= sel_pay;
            m_src_q   <= sel;
            rr_ptr    <= other_src(sel);
            if (sel == MEM_SRC_BVH) begin
                bvh_count <= bvh_count + 1'b1;
            end else begin
                fb_count <= fb_count + 1'b1;
            end
        end else if (m.ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m.valid = m_valid_q;
    assign m.addr  = m_pay_q[PAY_W-1 -: ADDR_W];
    assign m.data  = m_pay_q[MASK_W +: DATA_W];
    assign m.mask  = m_pay_q[MASK_W-1:0];
    assign m.src   = m_src_q;

endmodule
